// File: rtl/fb_write_arbiter_if.sv
// Host-side Avalon write port of the framebuffer write arbiter.
interface fb_write_arbiter_if #(
    parameter int unsigned AW = 15
);
    logic          chipselect;
    logic          write;
    logic [AW-1:0] address;
    logic [31:0]   writedata;
    logic          waitrequest;

    modport master (
        output chipselect, write, address, writedata,
        input  waitrequest
    );

    modport slave (
        input  chipselect, write, address, writedata,
        output waitrequest
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between the host bus and a fill engine,
// alternating grants while a fill runs so neither side starves.
module fb_write_arbiter #(
    parameter int unsigned DEPTH = 32768,
    parameter int unsigned AW    = 15
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_arbiter_if.slave host,
    input  logic              clear_start,
    input  logic [31:0]       clear_value,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ram_wren,
    output logic [AW-1:0]     ram_wraddress,
    output logic [31:0]       ram_data
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] fill_count;
    logic [31:0]   fill_value;
    logic          last_grant_host;

    logic host_req;
    logic host_grant;
    logic fill_grant;
    logic host_in_range;

    // A contested cycle goes to whichever side did not win the last grant.
    always_comb begin
        host_req         = host.chipselect & host.write;
        fill_grant       = (state == CLEAR) && (!host_req || last_grant_host);
        host_grant       = host_req && ((state == IDLE) || !last_grant_host);
        host.waitrequest = host_req && !host_grant;
        host_in_range    = 32'(host.address) < DEPTH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            fill_count      <= '0;
            fill_value      <= '0;
            last_grant_host <= 1'b1;
            clear_busy      <= 1'b0;
            clear_done      <= 1'b0;
            ram_wren        <= 1'b0;
            ram_wraddress   <= '0;
            ram_data        <= '0;
        end else begin
            ram_wren   <= 1'b0;
            clear_done <= 1'b0;

            // Out-of-range host writes are accepted but never reach the RAM.
            if (host_grant) begin
                last_grant_host <= 1'b1;
                if (host_in_range) begin
                    ram_wren      <= 1'b1;
                    ram_wraddress <= host.address;
                    ram_data      <= host.writedata;
                end
            end

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state           <= CLEAR;
                        fill_value      <= clear_value;
                        fill_count      <= '0;
                        clear_busy      <= 1'b1;
                        last_grant_host <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (fill_grant) begin
                        last_grant_host <= 1'b0;
                        ram_wren        <= 1'b1;
                        ram_wraddress   <= fill_count;
                        ram_data        <= fill_value;
                        if (fill_count == AW'(DEPTH - 1)) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            fill_count <= fill_count + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
